// File: rtl/uart_rx_if.sv
// Receiver-to-consumer handshake bundle: received word, status flags and acknowledge.
// The receiver drives the word and status (master); the consumer returns rx_ack (slave).
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx_ack;
  logic [DATA_BITS-1:0] d_out;
  logic                 rx_done_flag;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    input  rx_ack,
    output d_out,
    output rx_done_flag,
    output rx_valid,
    output frame_err,
    output overrun
  );

  modport slave (
    output rx_ack,
    input  d_out,
    input  rx_done_flag,
    input  rx_valid,
    input  frame_err,
    input  overrun
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: oversampled (s_tick) start/data/stop recovery, MSB first.
// The start bit is qualified at its centre, so every later sample also lands mid-bit.
// The FSM leaves STOP at mid-stop-bit so a back-to-back start edge is never missed.
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      s_tick,
  input  logic      rx,
  uart_rx_if.master bus
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int NW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [SW-1:0]        s_cnt_q, s_cnt_d;
  logic [NW-1:0]        n_cnt_q, n_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 sync1_q;
  logic                 rx_s_q;

  logic [DATA_BITS-1:0] d_out_q, d_out_d;
  logic                 rx_done_q, rx_done_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 done_s;

  // State, counters, synchronizer and registered outputs; synchronizer idles high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      s_cnt_q     <= '0;
      n_cnt_q     <= '0;
      shift_q     <= '0;
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      d_out_q     <= '0;
      rx_done_q   <= 1'b0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_cnt_q     <= s_cnt_d;
      n_cnt_q     <= n_cnt_d;
      shift_q     <= shift_d;
      sync1_q     <= rx;
      rx_s_q      <= sync1_q;
      d_out_q     <= d_out_d;
      rx_done_q   <= rx_done_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Next-state logic: frame sequencing and bit sampling, advanced only on s_tick.
  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_cnt_d = n_cnt_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          s_cnt_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_cnt_q == S_MID) begin
            if (!rx_s_q) begin
              state_d = DATA;
              s_cnt_d = '0;
              n_cnt_d = '0;
            end else begin
              // Line went back high before mid-start: treat as a glitch.
              state_d = IDLE;
            end
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_cnt_q == S_LAST) begin
            shift_d = {shift_q[DATA_BITS-2:0], rx_s_q};
            s_cnt_d = '0;
            if (n_cnt_q == N_LAST) begin
              state_d = STOP;
            end else begin
              n_cnt_d = n_cnt_q + NW'(1);
            end
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end else begin
          state_d = DATA;
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_cnt_q == S_LAST) begin
            state_d = IDLE;
            s_cnt_d = '0;
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
        s_cnt_d = '0;
        n_cnt_d = '0;
      end
    endcase
  end

  // Output logic: capture word/status at mid-stop-bit and run the valid/ack handshake.
  always_comb begin
    done_s      = (state_q == STOP) && s_tick && (s_cnt_q == S_LAST);
    rx_done_d   = done_s;
    d_out_d     = d_out_q;
    frame_err_d = frame_err_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = overrun_q;
    if (done_s) begin
      d_out_d     = shift_q;
      frame_err_d = ~rx_s_q;
      rx_valid_d  = 1'b1;
      // A coincident ack consumes the old word, so it is not an overrun.
      if (rx_valid_q && !bus.rx_ack) begin
        overrun_d = 1'b1;
      end else begin
        overrun_d = overrun_q;
      end
    end else if (bus.rx_ack) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
      overrun_d  = overrun_q;
    end
  end

  assign bus.d_out        = d_out_q;
  assign bus.rx_done_flag = rx_done_q;
  assign bus.rx_valid     = rx_valid_q;
  assign bus.frame_err    = frame_err_q;
  assign bus.overrun      = overrun_q;

endmodule
